// File: rtl/fpu_mc_seq.sv
// Multi-cycle FPU sequencer: stalls the core around FDIV.S/FSQRT.S, starts the
// iterative unit, waits for done or timeout, then performs a dedicated write-back cycle.
module fpu_mc_seq #(
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fpu_op,
    input  logic [4:0]  funct5,
    input  logic [4:0]  rd,
    input  logic        regwrite_in,
    input  logic        regwrite_f_in,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    input  logic        fflags_clr,
    output logic        fpu_start,
    output logic        stall,
    output logic        regwrite_out,
    output logic        regwrite_f_out,
    output logic        wb_sel,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  fflags,
    output logic        timeout_err,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned REG_W  = 5;
    localparam logic [DATA_W-1:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [FLAG_W-1:0] NV_FLAG   = 5'b10000;
    localparam logic [4:0]        F5_DIV    = 5'b00011;
    localparam logic [4:0]        F5_SQRT   = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [FLAG_W-1:0]   fflags_q, fflags_d;
    logic                timeout_err_q, timeout_err_d;
    logic                mc;

    // State and captured write-back context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            fflags_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            fflags_q      <= fflags_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic and pipeline control; decoder inputs only matter in IDLE
    always_comb begin
        mc             = fpu_op && (funct5 == F5_DIV || funct5 == F5_SQRT);
        state_d        = state_q;
        cnt_d          = cnt_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        fflags_d       = fflags_clr ? '0 : fflags_q;
        timeout_err_d  = timeout_err_q;
        fpu_start      = 1'b0;
        stall          = 1'b0;
        regwrite_out   = 1'b0;
        regwrite_f_out = 1'b0;
        wb_sel         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mc) begin
                    fpu_start = 1'b1;
                    stall     = 1'b1;
                    wb_rd_d   = rd;
                    cnt_d     = '0;
                    state_d   = ST_EXEC;
                end else begin
                    regwrite_out   = regwrite_in;
                    regwrite_f_out = regwrite_f_in;
                end
            end
            ST_EXEC: begin
                stall = 1'b1;
                // Done beats the timeout when both land in the same cycle
                if (fpu_done) begin
                    wb_data_d = fpu_result;
                    fflags_d  = fflags_d | fpu_flags;
                    state_d   = ST_WB;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    wb_data_d     = CANON_NAN;
                    fflags_d      = fflags_d | NV_FLAG;
                    timeout_err_d = 1'b1;
                    state_d       = ST_WB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                wb_sel         = 1'b1;
                regwrite_f_out = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign fflags      = fflags_q;
    assign timeout_err = timeout_err_q;

endmodule
